// File: rtl/pdes_event_dispatch_pkg.sv
// Shared definitions for the PHOLD event-dispatch controller: controller state
// encodings and the event word layout {lp, time}, with lp in the upper bits.
package pdes_event_dispatch_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INIT     = 3'd1;
    localparam logic [2:0] ST_RUNNING  = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_FINISHED = 3'd4;

    // Width of one event word: lp id bits sit directly above the timestamp bits.
    function automatic int evt_dw(input int lpw, input int tw);
        return lpw + tw;
    endfunction

endpackage

// File: rtl/pdes_event_dispatch_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer. On a consumed grant the pointer moves one past the granted index.
module pdes_rr_arb #(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_adv,
    output logic [N-1:0] o_gnt,
    output logic         o_valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_cand;

    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_idx   = r_ptr;
        w_cand  = r_ptr;
        for (int k = 0; k < N; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % N);
            if (!o_valid && i_req[w_cand]) begin
                o_gnt[w_cand] = 1'b1;
                o_valid       = 1'b1;
                w_idx         = w_cand;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_adv && o_valid) begin
            r_ptr <= (w_idx == PW'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/pdes_event_dispatch.sv
// Event-dispatch controller: seeds the event queue, arbitrates new core events
// into it, dispatches the earliest event to idle cores and tracks GVT.
module pdes_event_dispatch
    import pdes_event_dispatch_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int TW           = 16,
    parameter int LPW          = 3,
    parameter int SIM_END_TIME = 1000
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic [NUM_CORES-1:0]            i_core_new_vld,
    input  logic [NUM_CORES*(LPW+TW)-1:0]   i_core_new_data,
    output logic [NUM_CORES-1:0]            o_core_new_ack,
    input  logic [NUM_CORES-1:0]            i_core_ready,
    output logic [NUM_CORES-1:0]            o_core_evt_vld,
    output logic [LPW+TW-1:0]               o_core_evt_data,
    output logic                            o_q_enq,
    output logic                            o_q_deq,
    output logic [LPW+TW-1:0]               o_q_enq_data,
    input  logic [LPW+TW-1:0]               i_q_head,
    input  logic                            i_q_empty,
    input  logic                            i_q_full,
    output logic [TW-1:0]                   o_gvt,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [STATE_W-1:0]              o_dbg_state,
    output logic [NUM_CORES-1:0]            o_dbg_act
);

    localparam int DW       = evt_dw(LPW, TW);
    localparam int NUM_INIT = 2 ** LPW;

    logic [STATE_W-1:0]   r_state;
    logic [LPW:0]         r_init_cnt;
    logic [NUM_CORES-1:0] r_act;
    logic [TW-1:0]        r_loc_time [NUM_CORES];
    logic [TW-1:0]        r_gvt;

    logic                 w_running;
    logic                 w_accepting;
    logic                 w_init_push;
    logic [NUM_CORES-1:0] w_new_req;
    logic [NUM_CORES-1:0] w_new_gnt;
    logic                 w_new_valid;
    logic [DW-1:0]        w_new_slice;
    logic [NUM_CORES-1:0] w_disp_req;
    logic [NUM_CORES-1:0] w_disp_gnt;
    logic                 w_disp_valid;
    logic [TW-1:0]        w_head_time;

    assign w_running   = (r_state == ST_RUNNING);
    assign w_accepting = (r_state == ST_RUNNING) || (r_state == ST_DRAIN);
    assign w_init_push = (r_state == ST_INIT) && !i_q_full;
    assign w_head_time = i_q_head[TW-1:0];

    // Requests are pre-qualified so a grant always means a real transfer.
    assign w_new_req  = (w_accepting && !i_q_full) ? i_core_new_vld : '0;
    assign w_disp_req = (w_running && !w_new_valid && !i_q_empty)
                        ? (i_core_ready & ~r_act) : '0;

    pdes_rr_arb #(.N(NUM_CORES)) u_new_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (w_new_req),
        .i_adv   (w_new_valid),
        .o_gnt   (w_new_gnt),
        .o_valid (w_new_valid)
    );

    pdes_rr_arb #(.N(NUM_CORES)) u_disp_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (w_disp_req),
        .i_adv   (w_disp_valid),
        .o_gnt   (w_disp_gnt),
        .o_valid (w_disp_valid)
    );

    always_comb begin
        w_new_slice = '0;
        for (int g = 0; g < NUM_CORES; g++) begin
            if (w_new_gnt[g]) begin
                w_new_slice = i_core_new_data[g*DW +: DW];
            end
        end
    end

    assign o_core_new_ack  = w_new_gnt;
    assign o_core_evt_vld  = w_disp_gnt;
    assign o_core_evt_data = i_q_head;
    assign o_q_deq         = w_disp_valid;
    assign o_q_enq         = w_init_push | w_new_valid;
    assign o_q_enq_data    = w_init_push ? {r_init_cnt[LPW-1:0], {TW{1'b0}}} : w_new_slice;

    // GVT candidate chain: queue head first, then every active core's local time.
    logic [TW-1:0]      w_min [NUM_CORES+1];
    logic [NUM_CORES:0] w_min_vld;

    assign w_min[0]     = w_head_time;
    assign w_min_vld[0] = !i_q_empty;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_min
        assign w_min_vld[g+1] = w_min_vld[g] | r_act[g];
        assign w_min[g+1]     = (r_act[g] && (!w_min_vld[g] || (r_loc_time[g] < w_min[g])))
                                ? r_loc_time[g] : w_min[g];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_init_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state    <= ST_INIT;
                        r_init_cnt <= '0;
                    end
                end
                ST_INIT: begin
                    if (w_init_push) begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                        if (r_init_cnt == (LPW+1)'(NUM_INIT - 1)) begin
                            r_state <= ST_RUNNING;
                        end
                    end
                end
                ST_RUNNING: begin
                    if (r_gvt > TW'(SIM_END_TIME)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_act == '0) begin
                        r_state <= ST_FINISHED;
                    end
                end
                ST_FINISHED: r_state <= ST_IDLE;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_act <= '0;
            for (int g = 0; g < NUM_CORES; g++) begin
                r_loc_time[g] <= '0;
            end
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_act <= '0;
        end else begin
            for (int g = 0; g < NUM_CORES; g++) begin
                if (w_new_gnt[g]) begin
                    r_act[g] <= 1'b0;
                end
                if (w_disp_gnt[g]) begin
                    r_act[g]      <= 1'b1;
                    r_loc_time[g] <= w_head_time;
                end
            end
        end
    end

    // A fresh run starts GVT from zero; an empty candidate set leaves it held.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_gvt <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_gvt <= '0;
        end else if (w_accepting && w_min_vld[NUM_CORES]) begin
            r_gvt <= w_min[NUM_CORES];
        end
    end

    assign o_gvt       = r_gvt;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_FINISHED);
    assign o_dbg_state = r_state;
    assign o_dbg_act   = r_act;

endmodule

// File: tb/tb_pdes_event_dispatch.sv
// Directed bench for pdes_event_dispatch; queue pushes are checked against a
// scoreboard of expected event words, everything else by direct comparisons.
module tb_pdes_event_dispatch;
    import pdes_event_dispatch_pkg::*;

    localparam int NC  = 4;
    localparam int TW  = 16;
    localparam int LPW = 3;
    localparam int DW  = LPW + TW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [NC-1:0]     core_new_vld;
    logic [DW-1:0]     new_slice [NC];
    logic [NC*DW-1:0]  core_new_data;
    logic [NC-1:0]     core_new_ack;
    logic [NC-1:0]     core_ready;
    logic [NC-1:0]     core_evt_vld;
    logic [DW-1:0]     core_evt_data;
    logic              q_enq;
    logic              q_deq;
    logic [DW-1:0]     q_enq_data;
    logic [DW-1:0]     q_head;
    logic              q_empty;
    logic              q_full;
    logic [TW-1:0]     gvt;
    logic              busy;
    logic              done;
    logic [STATE_W-1:0] dbg_state;
    logic [NC-1:0]     dbg_act;

    logic [DW-1:0]     exp_q[$];
    logic [DW-1:0]     sb_exp;
    int                checks = 0;
    int                errors = 0;

    pdes_event_dispatch #(
        .NUM_CORES    (NC),
        .TW           (TW),
        .LPW          (LPW),
        .SIM_END_TIME (100)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_core_new_vld  (core_new_vld),
        .i_core_new_data (core_new_data),
        .o_core_new_ack  (core_new_ack),
        .i_core_ready    (core_ready),
        .o_core_evt_vld  (core_evt_vld),
        .o_core_evt_data (core_evt_data),
        .o_q_enq         (q_enq),
        .o_q_deq         (q_deq),
        .o_q_enq_data    (q_enq_data),
        .i_q_head        (q_head),
        .i_q_empty       (q_empty),
        .i_q_full        (q_full),
        .o_gvt           (gvt),
        .o_busy          (busy),
        .o_done          (done),
        .o_dbg_state     (dbg_state),
        .o_dbg_act       (dbg_act)
    );

    always #5 clk = ~clk;

    always_comb begin
        core_new_data = '0;
        for (int i = 0; i < NC; i++) begin
            core_new_data[i*DW +: DW] = new_slice[i];
        end
    end

    function automatic logic [DW-1:0] ev(input int lp, input int t);
        return {LPW'(lp), TW'(t)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every queue push seen mid-cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && q_enq) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected observed=%0h expected=none", q_enq_data);
                $error("unexpected push");
            end else begin
                sb_exp = exp_q.pop_front();
                assert (q_enq_data === sb_exp) else begin
                    errors++;
                    $display("FAIL sb_enq_data observed=%0h expected=%0h", q_enq_data, sb_exp);
                    $error("push data");
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; core_new_vld = '0; core_ready = '0;
        for (int i = 0; i < NC; i++) new_slice[i] = '0;
        q_head = '0; q_empty = 1'b1; q_full = 1'b0;
        tick(); tick();
        rst_n = 1'b1; #1;
        chk("rst_gvt", gvt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_act", dbg_act, 0);
        chk("rst_enq", q_enq, 0);

        // IDLE must ignore requesting and ready cores
        tick(); core_new_vld = 4'b1111; core_ready = 4'b1111; q_empty = 1'b0; q_head = ev(1, 3); #1;
        chk("idle_ack", core_new_ack, 0);
        chk("idle_evt", core_evt_vld, 0);
        chk("idle_deq", q_deq, 0);
        chk("idle_enq", q_enq, 0);

        tick(); core_new_vld = '0; core_ready = '0; q_empty = 1'b1; start = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(ev(i, 0));
        #1;
        chk("start_busy_lag", busy, 0);

        // INIT: eight back-to-back pushes, a mid-INIT start pulse is ignored
        tick(); start = 1'b0; #1;
        chk("init_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            start = (i == 2);
            #1;
            chk("init_enq", q_enq, 1);
            chk("init_state", dbg_state, ST_INIT);
        end
        tick(); start = 1'b0; #1;
        chk("init_to_run", dbg_state, ST_RUNNING);
        chk("run_enq_idle", q_enq, 0);

        // Contention: cores 1 and 3 acked in consecutive cycles, no dequeue
        tick(); new_slice[1] = ev(1, 30); new_slice[3] = ev(3, 40);
        core_new_vld = 4'b1010; core_ready = 4'b0101;
        exp_q.push_back(ev(1, 30)); exp_q.push_back(ev(3, 40)); #1;
        chk("cont_ack1", core_new_ack, 4'b0010);
        chk("cont_deq1", q_deq, 0);
        chk("cont_enq1", q_enq, 1);
        tick(); core_new_vld = 4'b1000; #1;
        chk("cont_ack3", core_new_ack, 4'b1000);
        chk("cont_deq3", q_deq, 0);

        // Dispatch and GVT lag
        tick(); core_new_vld = '0; q_empty = 1'b0; q_head = ev(5, 12); #1;
        chk("disp_evt0", core_evt_vld, 4'b0001);
        chk("disp_deq0", q_deq, 1);
        chk("disp_data0", core_evt_data, ev(5, 12));
        chk("disp_gvt_pre", gvt, 0);
        tick(); core_ready = 4'b0100; q_head = ev(2, 20); #1;
        chk("disp_gvt12", gvt, 12);
        chk("disp_evt2", core_evt_vld, 4'b0100);
        chk("disp_act0", dbg_act, 4'b0001);
        tick(); core_ready = '0; q_empty = 1'b1; #1;
        chk("disp_gvt_hold", gvt, 12);
        chk("disp_act02", dbg_act, 4'b0101);
        chk("disp_none", core_evt_vld, 0);

        // Back-pressure: q_full blocks core 2 for five cycles
        tick(); q_full = 1'b1; core_new_vld = 4'b0100; new_slice[2] = ev(6, 50); #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            #1;
            chk("bp_ack", core_new_ack, 0);
            chk("bp_enq", q_enq, 0);
        end
        tick(); q_full = 1'b0; exp_q.push_back(ev(6, 50)); #1;
        chk("bp_release_ack", core_new_ack, 4'b0100);
        chk("bp_release_enq", q_enq, 1);
        tick(); core_new_vld = '0; #1;
        chk("bp_act", dbg_act, 4'b0001);

        // Termination: core 1 busy at 103, queue holds only later events
        tick(); core_new_vld = 4'b0001; new_slice[0] = ev(0, 104); exp_q.push_back(ev(0, 104)); #1;
        chk("term_ack0", core_new_ack, 4'b0001);
        tick(); core_new_vld = '0; core_ready = 4'b0010; q_empty = 1'b0; q_head = ev(1, 103); #1;
        chk("term_act_clr", dbg_act, 0);
        chk("term_evt1", core_evt_vld, 4'b0010);
        chk("term_gvt12", gvt, 12);
        tick(); core_ready = '0; q_head = ev(2, 106); #1;
        chk("term_gvt103", gvt, 103);
        chk("term_still_run", dbg_state, ST_RUNNING);
        tick(); core_ready = 4'b1111; #1;
        chk("term_drain", dbg_state, ST_DRAIN);
        chk("drain_no_evt", core_evt_vld, 0);
        chk("drain_no_deq", q_deq, 0);
        tick(); core_ready = '0; core_new_vld = 4'b0010; new_slice[1] = ev(1, 107);
        exp_q.push_back(ev(1, 107)); #1;
        chk("drain_ack1", core_new_ack, 4'b0010);
        chk("drain_enq", q_enq, 1);
        tick(); core_new_vld = '0; #1;
        chk("drain_hold", dbg_state, ST_DRAIN);
        chk("drain_done0", done, 0);
        tick(); #1;
        chk("fin_state", dbg_state, ST_FINISHED);
        chk("fin_done", done, 1);
        chk("fin_gvt", gvt, 106);
        tick(); #1;
        chk("fin_idle", dbg_state, ST_IDLE);
        chk("fin_done_pulse", done, 0);
        chk("fin_busy", busy, 0);

        // Second run after reset: INIT stalls while the queue is full
        tick(); rst_n = 1'b0; q_empty = 1'b1;
        tick(); rst_n = 1'b1; start = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(ev(i, 0));
        tick(); start = 1'b0; #1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            q_full = (i == 3) || (i == 4);
            #1;
            chk("init2_enq", q_enq, (i == 3 || i == 4) ? 0 : 1);
            chk("init2_state", dbg_state, ST_INIT);
        end
        tick(); q_full = 1'b0; #1;
        chk("init2_run", dbg_state, ST_RUNNING);

        tick(); core_ready = 4'b1010; q_empty = 1'b0; q_head = ev(4, 60); #1;
        chk("run2_evt1", core_evt_vld, 4'b0010);
        tick(); core_ready = 4'b1000; q_head = ev(5, 70); #1;
        chk("run2_evt3", core_evt_vld, 4'b1000);
        tick(); core_ready = '0; q_empty = 1'b1; #1;
        chk("run2_act", dbg_act, 4'b1010);
        chk("run2_gvt", gvt, 60);

        // Mid-run reset drops everything
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1; core_new_vld = 4'b1111; core_ready = 4'b1111;
        q_empty = 1'b0; q_head = ev(0, 5); #1;
        chk("mrst_gvt", gvt, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_act", dbg_act, 0);
        chk("mrst_state", dbg_state, ST_IDLE);
        chk("mrst_ack", core_new_ack, 0);
        chk("mrst_evt", core_evt_vld, 0);
        chk("mrst_deq", q_deq, 0);
        chk("mrst_enq", q_enq, 0);
        tick(); core_new_vld = '0; core_ready = '0; q_empty = 1'b1; #1;
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdes_event_dispatch.md
# pdes_event_dispatch

Parametrised event-dispatch controller for the PHOLD PDES engine. It sits between NUM_CORES processing cores and the shared priority event queue. It seeds the queue with one initial event per LP, then runs three jobs: arbitrates new events from cores into the queue, dispatches the earliest event to an idle ready core, and maintains GVT until the end of simulation. Compared with the fixed 4-core controller, it adds configurable core/LP/time widths, queue back-pressure, correct per-core deactivation, queue-head inclusion in GVT, and a drain phase before completion.

## Interface
- NUM_CORES, 4, number of cores; must be ≥2.
- TW, 16, timestamp width.
- LPW, 3, LP id width; NUM_INIT = 2**LPW initial events.
- SIM_END_TIME, 1000, simulation ends once gvt > SIM_END_TIME; must be < 2**TW-1.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  pulse; leaves IDLE
- core_new_vld  in  NUM_CORES  core g holds a new event
- core_new_data  in  NUM_CORES*(LPW+TW)  slice g = {lp, time}
- core_new_ack  out  NUM_CORES  one-hot; event from core g accepted this cycle
- core_ready  in  NUM_CORES  core g can take an event
- core_evt_vld  out  NUM_CORES  one-hot dispatch strobe
- core_evt_data  out  LPW+TW  shared dispatch bus = q_head
- q_enq, q_deq  out  1  queue push/pop, sampled at clk edge
- q_enq_data  out  LPW+TW  push data {lp, time}
- q_head  in  LPW+TW  queue minimum; valid when !q_empty
- q_empty, q_full  in  1  queue status
- gvt  out  TW  global virtual time
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE → INIT on start.
  - INIT → RUNNING after NUM_INIT pushes.
  - RUNNING → DRAIN when gvt > SIM_END_TIME.
  - DRAIN → FINISHED when no core is active.
  - FINISHED → IDLE (done=1 during FINISHED).
- INIT:
  - q_enq = !q_full; q_enq_data = {init_cnt, 0}.
  - init_cnt (LPW+1 bits) increments only on a push, so a full queue stalls it.
- New-event path (RUNNING, DRAIN):
  - Round-robin arbiter over core_new_vld; the ack goes to the grant.
  - Active only when !q_full.
  - q_enq = 1 and q_enq_data = granted slice.
  - Acked core's act bit is cleared.
- Dispatch path (RUNNING only):
  - Condition: no enq this cycle, !q_empty, and any(core_ready & ~act).
  - Round-robin arbiter selects core g; core_evt_vld[g] = 1 and q_deq = 1.
  - Sets act[g] and loc_time[g] = q_head time.
  - Enqueue has priority over dispatch; enq and deq never occur in the same cycle.
- Arbiter pointers advance one past the granted index only on a grant; they are unchanged otherwise.
- GVT:
  - t_gvt = unsigned min over loc_time[g] where act[g], plus q_head time if !q_empty.
  - If that set is empty, gvt holds.
  - Updated only in RUNNING and DRAIN.
  - Widths: TW-bit unsigned compares, no wrap-around.
- Events left in the queue at FINISHED are not flushed. The queue's owner clears it.
- In IDLE, INIT and FINISHED, core_new_ack, core_evt_vld and q_deq are 0.

## Timing
- Reset values: all outputs 0; state IDLE; act=0; loc_time=0; both arbiter pointers at core 0; gvt=0; init_cnt=0.
- rst_n low mid-operation: on the next edge, full reset state and values as above. In-flight handshakes are dropped.
- core_new_ack, core_evt_vld, q_enq, q_deq and data outputs are combinational from current registers and inputs (same cycle).
- gvt is registered: it reflects act, loc_time and queue state from the previous cycle (1-cycle lag).
- Core handshake:
  - A core holds core_new_vld and data stable until acked.
  - A core deasserts core_ready the cycle after core_evt_vld.
- Simultaneous core_new_vld from k cores: acked over k consecutive cycles in round-robin order (with q_full low).
- start while busy is ignored.
- INIT latency is exactly NUM_INIT cycles with q_full low. busy rises the cycle after start.

## Structure
- Shared package/header holds the event field layout (lp above time, DW = LPW+TW) and the state encodings.
- One sub-module, `pdes_rr_arb #(N)`: inputs req, adv; outputs one-hot gnt and valid. Instantiated twice (new-event path, dispatch path).
- The GVT min-tree is a generate loop in the top. The queue stays external.

## Test plan
- Reset/init: NUM_CORES=4, LPW=3; pulse start → 8 consecutive q_enq with data {0..7, 0} → RUNNING; all outputs 0 before start.
- Contention: cores 1 and 3 assert core_new_vld, pointer at 0 → ack[1] in cycle n, ack[3] in cycle n+1, q_deq=0 in both cycles.
- Dispatch + GVT: q_head={5, 12}, cores 0 and 2 ready/idle, pointer at 0 → core_evt_vld=4'b0001, q_deq=1. Next head {2, 20} → gvt=12 one cycle later.
- Back-pressure: q_full=1 with core_new_vld[2]=1 for 5 cycles → no ack and no q_enq. q_full=0 → ack[2] in the same cycle.
- Termination: SIM_END_TIME=100; queue holds only events with time >105 and core 1 is active at 103 → DRAIN, no dispatch. Core 1 new event acked → FINISHED, done=1 for exactly one cycle → IDLE.
- Mid-run reset: rst_n=0 for one edge during RUNNING with act=4'b1010 → next cycle gvt=0, busy=0, act=0, no strobes.
